// File: rtl/r4_fft_pkg.sv
// Shared constants and elaboration-time helpers for the radix-4 SDF stages.
// Twiddle values are computed in integer Q30 arithmetic, then quantized.
package r4_fft_pkg;

  typedef enum logic [1:0] {
    PH_A = 2'd0,
    PH_B = 2'd1,
    PH_C = 2'd2,
    PH_D = 2'd3
  } phase_t;

  localparam longint ONE_Q30    = 64'sd1073741824;
  localparam longint TWO_PI_Q30 = 64'sd6746518852;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  // k index needs at least one bit even when N/4 == 1
  function automatic int idx_w(input int n);
    return (n > 4) ? clog2(n / 4) : 1;
  endfunction

  function automatic longint sat_lim(input int tw);
    return (64'sd1 <<< (tw - 1)) - 64'sd1;
  endfunction

  // sin/cos by Taylor series, x in Q30 within [0, pi/2)
  function automatic longint taylor(input longint x, input bit is_sin);
    longint term, sum, t1, t2;
    longint n;
    term = is_sin ? x : ONE_Q30;
    sum  = term;
    n    = is_sin ? 64'sd1 : 64'sd0;
    for (int i = 0; i < 12; i++) begin
      t1   = (term * x) >>> 30;
      t2   = (t1 * x) >>> 30;
      term = -(t2 / ((n + 1) * (n + 2)));
      n    = n + 2;
      sum  = sum + term;
    end
    return sum;
  endfunction

  // W_n^m = cos - j sin, rounded to Q1.(tw-1), +1.0 saturated
  function automatic longint tw_q(input int m, input int n,
                                  input int tw, input bit im);
    int     mm, q, r;
    longint phi, c, s, cv, sv, v, qv;
    mm  = m % n;
    q   = mm / (n / 4);
    r   = mm % (n / 4);
    phi = (TWO_PI_Q30 * longint'(r)) / longint'(n);
    c   = taylor(phi, 1'b0);
    s   = taylor(phi, 1'b1);
    case (q)
      0:       begin cv = c;  sv = s;  end
      1:       begin cv = -s; sv = c;  end
      2:       begin cv = -c; sv = -s; end
      default: begin cv = s;  sv = -c; end
    endcase
    v  = im ? -sv : cv;
    qv = ((v <<< (tw - 1)) + (ONE_Q30 >>> 1)) >>> 30;
    if (qv > sat_lim(tw)) qv = sat_lim(tw);
    return qv;
  endfunction

endpackage

// File: rtl/r4_twiddle_rom.sv
// Registered twiddle lookup: W^k, W^2k, W^3k for one radix-4 stage.
// Table contents are constants computed at elaboration.
module r4_twiddle_rom
  import r4_fft_pkg::*;
#(
  parameter int N  = 16,
  parameter int TW = 16,
  parameter int IW = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic [IW-1:0]        k,
  output logic signed [TW-1:0] w0r,
  output logic signed [TW-1:0] w0i,
  output logic signed [TW-1:0] w1r,
  output logic signed [TW-1:0] w1i,
  output logic signed [TW-1:0] w2r,
  output logic signed [TW-1:0] w2i
);

  localparam int D = 2 ** IW;

  logic signed [TW-1:0] t0r [D];
  logic signed [TW-1:0] t0i [D];
  logic signed [TW-1:0] t1r [D];
  logic signed [TW-1:0] t1i [D];
  logic signed [TW-1:0] t2r [D];
  logic signed [TW-1:0] t2i [D];

  for (genvar g = 0; g < D; g++) begin : g_rom
    localparam logic signed [TW-1:0] C0R = TW'(tw_q(g, N, TW, 1'b0));
    localparam logic signed [TW-1:0] C0I = TW'(tw_q(g, N, TW, 1'b1));
    localparam logic signed [TW-1:0] C1R = TW'(tw_q(2*g, N, TW, 1'b0));
    localparam logic signed [TW-1:0] C1I = TW'(tw_q(2*g, N, TW, 1'b1));
    localparam logic signed [TW-1:0] C2R = TW'(tw_q(3*g, N, TW, 1'b0));
    localparam logic signed [TW-1:0] C2I = TW'(tw_q(3*g, N, TW, 1'b1));
    assign t0r[g] = C0R;
    assign t0i[g] = C0I;
    assign t1r[g] = C1R;
    assign t1i[g] = C1I;
    assign t2r[g] = C2R;
    assign t2i[g] = C2I;
  end

  // latch the three twiddles alongside the data tuple
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w0r <= '0;
      w0i <= '0;
      w1r <= '0;
      w1i <= '0;
      w2r <= '0;
      w2i <= '0;
    end else if (en) begin
      w0r <= t0r[k];
      w0i <= t0i[k];
      w1r <= t1r[k];
      w1i <= t1i[k];
      w2r <= t2r[k];
      w2i <= t2i[k];
    end
  end

endmodule

// File: rtl/r4_sdf_feeder.sv
// Radix-4 SDF input stage: gathers x[k], x[k+N/4], x[k+N/2], x[k+3N/4].
// Optional R4_FEEDER_SCALE_EN pre-scales samples by 1/4 (floor).
module r4_sdf_feeder
  import r4_fft_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 16,
  parameter  int TW    = WIDTH / 2,
  localparam int IW    = idx_w(N)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_r,
  input  logic signed [WIDTH-1:0] in_i,
  output logic signed [WIDTH-1:0] ar,
  output logic signed [WIDTH-1:0] ai,
  output logic signed [WIDTH-1:0] br,
  output logic signed [WIDTH-1:0] bi,
  output logic signed [WIDTH-1:0] cr,
  output logic signed [WIDTH-1:0] ci,
  output logic signed [WIDTH-1:0] dr,
  output logic signed [WIDTH-1:0] di,
  output logic signed [TW-1:0]    w0r,
  output logic signed [TW-1:0]    w0i,
  output logic signed [TW-1:0]    w1r,
  output logic signed [TW-1:0]    w1i,
  output logic signed [TW-1:0]    w2r,
  output logic signed [TW-1:0]    w2i,
  output logic                    start,
  output logic [IW-1:0]           idx,
  output logic                    blk_last
);

  localparam int CW = clog2(N);
  localparam int NQ = N / 4;
  localparam int D  = 2 ** IW;

  logic [CW-1:0]           cnt;
  phase_t                  phase;
  logic [IW-1:0]           k;
  logic                    wr;
  logic                    fire;
  logic signed [WIDTH-1:0] s_r;
  logic signed [WIDTH-1:0] s_i;

  logic signed [WIDTH-1:0] buf_r [3][D];
  logic signed [WIDTH-1:0] buf_i [3][D];

`ifdef R4_FEEDER_SCALE_EN
  assign s_r = in_r >>> 2;
  assign s_i = in_i >>> 2;
`else
  assign s_r = in_r;
  assign s_i = in_i;
`endif

  assign phase = phase_t'(cnt[CW-1 -: 2]);
  assign k     = IW'(cnt % CW'(NQ));
  assign wr    = in_valid && !flush && (phase != PH_D);
  assign fire  = in_valid && !flush && (phase == PH_D);

  // sample counter; flush drops the partial block
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         cnt <= '0;
    else if (flush)    cnt <= '0;
    else if (in_valid) cnt <= cnt + 1'b1;
  end

  // delay buffers for the first three quarters of the block
  always_ff @(posedge clock) begin
    if (wr) begin
      buf_r[phase][k] <= s_r;
      buf_i[phase][k] <= s_i;
    end
  end

  // registered tuple and control outputs, held between tuples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ar       <= '0;
      ai       <= '0;
      br       <= '0;
      bi       <= '0;
      cr       <= '0;
      ci       <= '0;
      dr       <= '0;
      di       <= '0;
      idx      <= '0;
      start    <= 1'b0;
      blk_last <= 1'b0;
    end else begin
      start    <= fire;
      blk_last <= fire && (k == IW'(NQ - 1));
      if (fire) begin
        ar  <= buf_r[0][k];
        ai  <= buf_i[0][k];
        br  <= buf_r[1][k];
        bi  <= buf_i[1][k];
        cr  <= buf_r[2][k];
        ci  <= buf_i[2][k];
        dr  <= s_r;
        di  <= s_i;
        idx <= k;
      end
    end
  end

  r4_twiddle_rom #(
    .N  (N),
    .TW (TW),
    .IW (IW)
  ) u_rom (
    .clock (clock),
    .reset (reset),
    .en    (fire),
    .k     (k),
    .w0r   (w0r),
    .w0i   (w0i),
    .w1r   (w1r),
    .w1i   (w1i),
    .w2r   (w2r),
    .w2i   (w2i)
  );

endmodule

// File: tb/tb_r4_sdf_feeder.sv
// Directed bench for r4_sdf_feeder (N=16, WIDTH=32, TW=16).
// Expected tuples are queued as samples are driven and popped on start.
module tb_r4_sdf_feeder;

  localparam int WIDTH = 32;
  localparam int N     = 16;
  localparam int TW    = 16;
  localparam real PI   = 3.14159265358979323846;

`ifdef R4_FEEDER_SCALE_EN
  localparam int A_POS = 250;
  localparam int A_NEG = -1;
`else
  localparam int A_POS = 1000;
  localparam int A_NEG = -3;
`endif

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    flush = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [WIDTH-1:0] in_r = '0;
  logic signed [WIDTH-1:0] in_i = '0;
  logic signed [WIDTH-1:0] ar, ai, br, bi, cr, ci, dr, di;
  logic signed [TW-1:0]    w0r, w0i, w1r, w1i, w2r, w2i;
  logic                    start;
  logic [1:0]              idx;
  logic                    blk_last;

  r4_sdf_feeder #(.WIDTH(WIDTH), .N(N), .TW(TW)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_r     (in_r),
    .in_i     (in_i),
    .ar       (ar),
    .ai       (ai),
    .br       (br),
    .bi       (bi),
    .cr       (cr),
    .ci       (ci),
    .dr       (dr),
    .di       (di),
    .w0r      (w0r),
    .w0i      (w0i),
    .w1r      (w1r),
    .w1i      (w1i),
    .w2r      (w2r),
    .w2i      (w2i),
    .start    (start),
    .idx      (idx),
    .blk_last (blk_last)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic signed [WIDTH-1:0] ar, ai, br, bi, cr, ci, dr, di;
    logic signed [TW-1:0]    w0r, w0i, w1r, w1i, w2r, w2i;
    logic [1:0]              idx;
    logic                    last;
  } tup_t;

  tup_t                    sb[$];
  tup_t                    got_t, exp_t;
  int                      checks = 0;
  int                      errors = 0;
  int                      starts = 0;
  int                      s0;
  int                      mcnt = 0;
  logic signed [WIDTH-1:0] hr [16];
  logic signed [WIDTH-1:0] hi [16];
  logic signed [TW-1:0]    cap_w [4][6];
  logic signed [WIDTH-1:0] cap_a0 = '0;

  function automatic logic signed [TW-1:0] qtw(real v);
    real t;
    t = $floor(v * 32768.0 + 0.5);
    if (t > 32767.0) t = 32767.0;
    return TW'($rtoi(t));
  endfunction

  function automatic logic signed [WIDTH-1:0] scl(logic signed [WIDTH-1:0] x);
`ifdef R4_FEEDER_SCALE_EN
    return x >>> 2;
`else
    return x;
`endif
  endfunction

  task automatic push_exp(int kk);
    tup_t e;
    real  t0, t1, t2;
    t0 = 2.0 * PI * real'(kk) / 16.0;
    t1 = 2.0 * PI * real'(2 * kk) / 16.0;
    t2 = 2.0 * PI * real'(3 * kk) / 16.0;
    e.ar   = hr[kk];
    e.ai   = hi[kk];
    e.br   = hr[kk+4];
    e.bi   = hi[kk+4];
    e.cr   = hr[kk+8];
    e.ci   = hi[kk+8];
    e.dr   = hr[kk+12];
    e.di   = hi[kk+12];
    e.w0r  = qtw($cos(t0));
    e.w0i  = qtw(-$sin(t0));
    e.w1r  = qtw($cos(t1));
    e.w1i  = qtw(-$sin(t1));
    e.w2r  = qtw($cos(t2));
    e.w2i  = qtw(-$sin(t2));
    e.idx  = 2'(kk);
    e.last = (kk == 3);
    sb.push_back(e);
  endtask

  task automatic step(bit v, int r, int i, bit fl = 1'b0);
    @(posedge clock);
    #1;
    in_valid = v;
    in_r     = r;
    in_i     = i;
    flush    = fl;
    if (fl) begin
      mcnt = 0;
    end else if (v) begin
      hr[mcnt] = scl(r);
      hi[mcnt] = scl(i);
      if (mcnt >= 12) push_exp(mcnt - 12);
      mcnt = (mcnt + 1) % 16;
    end
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) step(1'b0, 0, 0);
  endtask

  task automatic chk(string tag, logic signed [63:0] got,
                     logic signed [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drain();
    for (int j = 0; j < 20 && sb.size() != 0; j++) @(negedge clock);
    chk("sb_drain", sb.size(), 0);
  endtask

  // scoreboard: every start must match the oldest queued tuple
  always @(negedge clock) begin
    if (start) begin
      starts++;
      got_t = '{ar, ai, br, bi, cr, ci, dr, di,
                w0r, w0i, w1r, w1i, w2r, w2i, idx, blk_last};
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_start got idx=%0d expected no start", idx);
      end
      if (sb.size() != 0) begin
        exp_t = sb.pop_front();
        checks++;
        assert (got_t === exp_t)
        else begin
          errors++;
          $error("FAIL tuple k=%0d got %h expected %h", idx, got_t, exp_t);
        end
      end
      cap_w[idx] = '{w0r, w0i, w1r, w1i, w2r, w2i};
      if (idx == 2'd0) cap_a0 = ar;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clock);
    chk("rst_start", start, 0);
    chk("rst_ar", ar, 0);
    chk("rst_di", di, 0);
    chk("rst_w0r", w0r, 0);
    chk("rst_idx", idx, 0);
    chk("rst_last", blk_last, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    idle(5);
    @(negedge clock);
    chk("idle_starts", starts, 0);

    // impulse
    s0 = starts;
    step(1'b1, 1000, 0);
    for (int n = 1; n < 16; n++) step(1'b1, 0, 0);
    idle(2);
    drain();
    chk("imp_starts", starts - s0, 4);
    chk("imp_a0", cap_a0, A_POS);
    chk("imp_w0r", cap_w[0][0], 32767);
    chk("imp_w0i", cap_w[0][1], 0);
    chk("imp_w2r", cap_w[0][4], 32767);

    // continuous ramp with per-cycle start timing
    s0 = starts;
    for (int n = 0; n < 17; n++) begin
      if (n < 16) step(1'b1, n, 0);
      else        step(1'b0, 0, 0);
      @(negedge clock);
      if (n > 0) chk("ramp_start_t", start, (n - 1) >= 12);
    end
    idle(1);
    drain();
    chk("ramp_starts", starts - s0, 4);
    chk("k1_w0r", cap_w[1][0], 30274);
    chk("k1_w0i", cap_w[1][1], -12540);
    chk("k1_w1r", cap_w[1][2], 23170);
    chk("k1_w1i", cap_w[1][3], -23170);
    chk("k1_w2r", cap_w[1][4], 12540);
    chk("k1_w2i", cap_w[1][5], -30274);

    // ramp with random gaps
    s0 = starts;
    for (int n = 0; n < 16; n++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 0, 0);
      step(1'b1, n, 0);
    end
    idle(2);
    drain();
    chk("gap_starts", starts - s0, 4);

    // flush after 7 samples; flush with valid drops the sample
    s0 = starts;
    for (int n = 0; n < 7; n++) step(1'b1, 500 + n, 0);
    step(1'b1, 99, 0, 1'b1);
    for (int n = 0; n < 16; n++) step(1'b1, n, 0);
    idle(2);
    drain();
    chk("flush_starts", starts - s0, 4);

    // async reset in phase 3, after two tuples have gone out
    for (int n = 0; n < 14; n++) step(1'b1, 700 + n, 3);
    idle(2);
    drain();
    @(negedge clock);
    #1 reset = 1'b1;
    mcnt = 0;
    #2 reset = 1'b0;
    s0 = starts;
    for (int n = 0; n < 16; n++) step(1'b1, n, 0);
    idle(2);
    drain();
    chk("rst_mid_starts", starts - s0, 4);

    // negative impulse: floor behaviour of the optional pre-scale
    step(1'b1, -3, 0);
    for (int n = 1; n < 16; n++) step(1'b1, 0, 0);
    idle(2);
    drain();
    chk("neg_a0", cap_a0, A_NEG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
